// File: rtl/mul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_pkg
//  Description : Shared types and helpers for the sequential shift-add
//                multiplier: controller state encoding and the iteration
//                counter width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_seq_pkg;

  // Controller states: accept operands, iterate over multiplier bits,
  // sign-correct and publish the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Bits needed to hold an iteration count from w down to 0.
  function automatic int count_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_cond_neg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_cond_neg
//  Description : Combinational conditional two's-complement negation.
//                Used to take operand magnitudes and to re-apply the sign
//                to the unsigned product.
//  Revision    : 1.0 - initial release
//
//  Ports
//    in_val   in  W   value to pass through or negate
//    neg      in  1   1 = output -in_val, 0 = output in_val
//    out_val  out W   result (modulo 2^W)
// ============================================================================
module mul_cond_neg #(
  parameter int W = 11
) (
  input  logic [W-1:0] in_val,
  input  logic         neg,
  output logic [W-1:0] out_val
);

  // Negating zero yields zero, so a signed zero product never becomes
  // a "negative zero".
  assign out_val = neg ? (-in_val) : in_val;

endmodule
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq
//  Description : Sequential shift-add multiplier with start/done handshake
//                and per-operation signed/unsigned mode. One multiplier bit
//                is retired per clock; add and shift share a single cycle.
//                Signed operands are reduced to magnitudes on capture and
//                the sign is re-applied once in the FIX state.
//  Revision    : 1.0 - initial release
//
//  Optional feature macro: MUL_SEQ_ACCUMULATE_EN
//    When defined, adds input acc_en; an operation captured with acc_en=1
//    adds its signed result onto the held product (wrapping).
//
//  Ports
//    clock         in  1       rising-edge clock
//    reset         in  1       asynchronous active-low reset
//    start         in  1       request, sampled only in IDLE
//    signed_mode   in  1       1 = two's-complement operands
//    multiplicand  in  W_MULTIPLICAND
//    multiplier    in  W_MULTIPLIER
//    acc_en        in  1       (MUL_SEQ_ACCUMULATE_EN only) accumulate mode
//    busy          out 1       high from CALC through FIX
//    done          out 1       one-cycle pulse, product valid
//    product       out W_MULTIPLICAND+W_MULTIPLIER, held until next done
// ============================================================================
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int W_MULTIPLICAND = 11,
  parameter int W_MULTIPLIER   = 11
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   signed_mode,
  input  logic [W_MULTIPLICAND-1:0]              multiplicand,
  input  logic [W_MULTIPLIER-1:0]                multiplier,
`ifdef MUL_SEQ_ACCUMULATE_EN
  input  logic                                   acc_en,
`endif
  output logic                                   busy,
  output logic                                   done,
  output logic [W_MULTIPLICAND+W_MULTIPLIER-1:0] product
);

  localparam int W_PRODUCT = W_MULTIPLICAND + W_MULTIPLIER;
  localparam int W_COUNT   = count_width(W_MULTIPLIER);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                      state_q,   state_d;
  logic [W_MULTIPLICAND-1:0]   mcand_q,   mcand_d;    // |multiplicand|
  logic [W_MULTIPLICAND-1:0]   acc_q,     acc_d;      // upper partial product (A)
  logic [W_MULTIPLIER-1:0]     q_q,       q_d;        // multiplier / lower product (Q)
  logic                        neg_q,     neg_d;      // result must be negated
  logic [W_COUNT-1:0]          count_q,   count_d;
  logic [W_PRODUCT-1:0]        product_q, product_d;
  logic                        done_q,    done_d;
`ifdef MUL_SEQ_ACCUMULATE_EN
  logic                        accum_q,   accum_d;
`endif

  // --------------------------------------------------------------------------
  // Operand magnitudes and result sign correction
  // --------------------------------------------------------------------------
  logic [W_MULTIPLICAND-1:0] a_mag;
  logic [W_MULTIPLIER-1:0]   b_mag;
  logic [W_PRODUCT-1:0]      signed_result;
  logic                      a_sign;
  logic                      b_sign;

  assign a_sign = signed_mode & multiplicand[W_MULTIPLICAND-1];
  assign b_sign = signed_mode & multiplier[W_MULTIPLIER-1];

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude 2^(W-1); no extra bit is needed.
  mul_cond_neg #(.W(W_MULTIPLICAND)) u_neg_a (
    .in_val  (multiplicand),
    .neg     (a_sign),
    .out_val (a_mag)
  );

  mul_cond_neg #(.W(W_MULTIPLIER)) u_neg_b (
    .in_val  (multiplier),
    .neg     (b_sign),
    .out_val (b_mag)
  );

  mul_cond_neg #(.W(W_PRODUCT)) u_neg_res (
    .in_val  ({acc_q, q_q}),
    .neg     (neg_q),
    .out_val (signed_result)
  );

  // --------------------------------------------------------------------------
  // Add step: the MSB of the sum plays the role of the carry register E.
  // It is consumed by the shift in the same cycle, so E is never stored.
  // --------------------------------------------------------------------------
  logic [W_MULTIPLICAND:0] sum;

  always_comb begin
    sum = {1'b0, acc_q};
    if (q_q[0]) begin
      sum = {1'b0, acc_q} + {1'b0, mcand_q};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    q_d       = q_q;
    neg_d     = neg_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
`ifdef MUL_SEQ_ACCUMULATE_EN
    accum_d   = accum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_mag;
          q_d     = b_mag;
          neg_d   = a_sign ^ b_sign;
          acc_d   = '0;
          count_d = W_COUNT'(W_MULTIPLIER);
`ifdef MUL_SEQ_ACCUMULATE_EN
          accum_d = acc_en;
`endif
          state_d = CALC;
        end
      end

      CALC: begin
        // {E,A,Q} >> 1 after the conditional add.
        acc_d   = sum[W_MULTIPLICAND:1];
        q_d     = {sum[0], q_q[W_MULTIPLIER-1:1]};
        count_d = count_q - W_COUNT'(1);
        if (count_q == W_COUNT'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
`ifdef MUL_SEQ_ACCUMULATE_EN
        product_d = accum_q ? (product_q + signed_result) : signed_result;
`else
        product_d = signed_result;
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifdef MUL_SEQ_ACCUMULATE_EN
      accum_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      neg_q     <= neg_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
`ifdef MUL_SEQ_ACCUMULATE_EN
      accum_q   <= accum_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq
//  Description : Self-checking bench for mul_seq. A cycle-level model of
//                the handshake (accept edge, busy window, done edge) and an
//                arithmetic product model are compared against the DUT on
//                every falling edge; directed operations also pin literal
//                products and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq;

  localparam int WA = 11;
  localparam int WB = 11;
  localparam int WP = WA + WB;
  localparam longint MASK = (longint'(1) << WP) - 1;

  logic          clock;
  logic          reset;
  logic          start;
  logic          signed_mode;
  logic [WA-1:0] multiplicand;
  logic [WB-1:0] multiplier;
  logic          acc_en;
  logic          busy;
  logic          done;
  logic [WP-1:0] product;

  mul_seq #(
    .W_MULTIPLICAND (WA),
    .W_MULTIPLIER   (WB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef MUL_SEQ_ACCUMULATE_EN
    .acc_en       (acc_en),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed/unsigned product reduced to the product width.
  function automatic longint model_mul(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                       input logic sm);
    longint av;
    longint bv;
    av = sm ? longint'($signed(a)) : longint'(a);
    bv = sm ? longint'($signed(b)) : longint'(b);
    return (av * bv) & MASK;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake model: an operation accepted at rising edge c0 keeps busy high
  // for the falling edges after edges c0..c0+WB, shows done after edge
  // c0+WB+1, and a new start is accepted from edge c0+WB+2 on.
  // --------------------------------------------------------------------------
  int     cyc = 0;
  int     c0  = 0;
  logic   pending = 1'b0;
  longint m_res   = 0;
  logic   m_acc   = 1'b0;
  longint m_prod  = 0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!reset) begin
      pending = 1'b0;
    end else if (start && (!pending || cyc >= c0 + WB + 2)) begin
      pending = 1'b1;
      c0      = cyc;
      m_res   = model_mul(multiplicand, multiplier, signed_mode);
      m_acc   = acc_en;
    end
  end

  always @(negedge clock) begin
    logic exp_busy;
    logic exp_done;
    if (!reset) begin
      m_prod = 0;
      check("busy_in_reset", busy, 0);
      check("done_in_reset", done, 0);
      check("product_in_reset", product, 0);
    end else begin
      exp_busy = pending && (cyc >= c0) && (cyc <= c0 + WB);
      exp_done = pending && (cyc == c0 + WB + 1);
      if (exp_done) begin
        m_prod = m_acc ? ((m_prod + m_res) & MASK) : m_res;
      end
      check("model_busy", busy, exp_busy);
      check("model_done", done, exp_done);
      check("model_product", product, m_prod);
    end
  end

  // --------------------------------------------------------------------------
  // Directed operation: call at a falling edge. Drives start for one cycle,
  // scrambles operands after capture, optionally re-pulses start at falling
  // edge index glitch (ignored by the DUT), and checks latency and product.
  // --------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [WA-1:0] a, input logic [WB-1:0] b,
                        input logic sm, input logic acc, input longint exp_prod,
                        input int glitch);
    int n;
    int bcnt;
    multiplicand = a;
    multiplier   = b;
    signed_mode  = sm;
    acc_en       = acc;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    signed_mode  = ~sm;
    acc_en       = ~acc;
    n    = 0;
    bcnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bcnt++;
      if (n == glitch) begin
        start        = 1'b1;
        multiplicand = 11'd100;
        multiplier   = 11'd100;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    check({name, "_done_edges"}, n + 1, WB + 2);
    check({name, "_busy_cycles"}, bcnt, WB + 1);
    check({name, "_product"}, product, exp_prod);
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    acc_en       = 1'b0;

    @(negedge clock);
    @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    reset = 1'b1;
    @(negedge clock);

    run_op("u3x5",       11'd3,     11'd5,     1'b0, 1'b0, 15,        -1);
    run_op("s_m7x5",     11'h7F9,   11'd5,     1'b1, 1'b0, 'h3FFFDD,  -1);
    run_op("s_min_min",  11'h400,   11'h400,   1'b1, 1'b0, 'h100000,  -1);
    run_op("u_max_max",  11'h7FF,   11'h7FF,   1'b0, 1'b0, 4190209,   -1);
    run_op("s_0xm1",     11'd0,     11'h7FF,   1'b1, 1'b0, 0,         -1);
    run_op("u9x9_glitch",11'd9,     11'd9,     1'b0, 1'b0, 81,         4);
    // Issued in the done cycle of the previous operation.
    run_op("b2b_12x11",  11'd12,    11'd11,    1'b0, 1'b0, 132,       -1);

    // Asynchronous reset in the middle of CALC.
    multiplicand = 11'd100;
    multiplier   = 11'd3;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    check("async_reset_product", product, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_idle_busy", busy, 0);
    run_op("u6x7",       11'd6,     11'd7,     1'b0, 1'b0, 42,        -1);

`ifdef MUL_SEQ_ACCUMULATE_EN
    run_op("acc_10x10",  11'd10,    11'd10,    1'b0, 1'b0, 100,       -1);
    run_op("acc_m3x4",   11'h7FD,   11'd4,     1'b1, 1'b1, 88,        -1);
`endif

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
